// File: rtl/pio_out_pulse.sv
// Parametrised Avalon-MM output PIO with atomic SET/CLR/TOGGLE writes,
// a one-shot pulse engine that inverts selected bits for N clocks, and a status register.
module pio_out_pulse #(
  parameter int unsigned             DATA_WIDTH        = 16,
  parameter logic [DATA_WIDTH-1:0]   RESET_VALUE       = '0,
  parameter int unsigned             CNT_WIDTH         = 16,
  parameter logic [CNT_WIDTH-1:0]    DEFAULT_PULSE_LEN = CNT_WIDTH'(1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  pulse_busy
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE = 3'd3;
  localparam logic [2:0] ADDR_LEN    = 3'd4;
  localparam logic [2:0] ADDR_PULSE  = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   pmask_q, pmask_d;
  logic [CNT_WIDTH-1:0]    pulse_len_q, pulse_len_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic                    wrEn;
  logic                    pulseWr;
  logic [DATA_WIDTH-1:0]   wdData;
  logic [CNT_WIDTH-1:0]    wdCnt;
  logic [CNT_WIDTH-1:0]    effLen;
  logic                    unusedWriteData;

  assign wrEn    = chipselect && !write_n;
  assign pulseWr = wrEn && (address == ADDR_PULSE);
  assign wdData  = writedata[DATA_WIDTH-1:0];
  assign wdCnt   = writedata[CNT_WIDTH-1:0];
  assign unusedWriteData = ^writedata;

  // A programmed length of zero still produces a one-cycle pulse.
  assign effLen = (pulse_len_q == '0) ? CNT_WIDTH'(1) : pulse_len_q;

  always_comb begin
    data_d      = data_q;
    pulse_len_d = pulse_len_q;
    if (wrEn) begin
      case (address)
        ADDR_DATA:   data_d      = wdData;
        ADDR_SET:    data_d      = data_q | wdData;
        ADDR_CLR:    data_d      = data_q & ~wdData;
        ADDR_TOGGLE: data_d      = data_q ^ wdData;
        ADDR_LEN:    pulse_len_d = wdCnt;
        default:     ;
      endcase
    end
  end

  // A PULSE write while active wins over expiry: nonzero mask retriggers, zero mask aborts.
  always_comb begin
    state_d = state_q;
    pmask_d = pmask_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pulseWr && (wdData != '0)) begin
          pmask_d = wdData;
          cnt_d   = effLen;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pulseWr) begin
          if (wdData != '0) begin
            pmask_d = wdData;
            cnt_d   = effLen;
          end else begin
            pmask_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else if (cnt_q == CNT_WIDTH'(1)) begin
          pmask_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: begin
        pmask_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      data_q      <= RESET_VALUE;
      pmask_q     <= '0;
      pulse_len_q <= DEFAULT_PULSE_LEN;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      pmask_q     <= pmask_d;
      pulse_len_q <= pulse_len_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLR, ADDR_TOGGLE: readdata = 32'(data_q);
      ADDR_LEN:    readdata = 32'(pulse_len_q);
      ADDR_PULSE:  readdata = 32'(pmask_q);
      ADDR_STATUS: readdata = (32'(cnt_q) << 16) | 32'(state_q == ACTIVE);
      default:     readdata = '0;
    endcase
  end

  assign out_port   = data_q ^ pmask_q;
  assign pulse_busy = (state_q == ACTIVE);

endmodule
